// File: rtl/ex_unit_mdu.sv
// Registered RV32I/M execute unit: single-cycle ALU, two-stage multiplier and a
// restoring divider (one quotient bit per cycle) behind valid/ready handshakes.
module ex_unit_mdu #(
  parameter int XLEN     = 32,
  parameter int REGIDX_W = 5,
  parameter int OP_W     = 5
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                valid_in,
  output logic                ready_out,
  input  logic [OP_W-1:0]     op_in,
  input  logic                rdE_in,
  input  logic [REGIDX_W-1:0] rdIdx_in,
  input  logic [XLEN-1:0]     rs1Data_in,
  input  logic [XLEN-1:0]     rs2Data_in,
  input  logic                flush_in,
  output logic                valid_out,
  input  logic                ready_in,
  output logic                rdE_out,
  output logic [REGIDX_W-1:0] rdIdx_out,
  output logic [XLEN-1:0]     rdData_out,
  output logic                busy_out
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [OP_W-1:0] OP_ADD    = OP_W'(5'd0);
  localparam logic [OP_W-1:0] OP_SUB    = OP_W'(5'd1);
  localparam logic [OP_W-1:0] OP_SLL    = OP_W'(5'd2);
  localparam logic [OP_W-1:0] OP_SLT    = OP_W'(5'd3);
  localparam logic [OP_W-1:0] OP_SLTU   = OP_W'(5'd4);
  localparam logic [OP_W-1:0] OP_XOR    = OP_W'(5'd5);
  localparam logic [OP_W-1:0] OP_SRL    = OP_W'(5'd6);
  localparam logic [OP_W-1:0] OP_SRA    = OP_W'(5'd7);
  localparam logic [OP_W-1:0] OP_OR     = OP_W'(5'd8);
  localparam logic [OP_W-1:0] OP_AND    = OP_W'(5'd9);
  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(5'd10);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(5'd11);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(5'd12);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(5'd13);
  localparam logic [OP_W-1:0] OP_DIV    = OP_W'(5'd14);
  localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(5'd15);
  localparam logic [OP_W-1:0] OP_REM    = OP_W'(5'd16);
  localparam logic [OP_W-1:0] OP_REMU   = OP_W'(5'd17);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_OUT  = 3'd2,
    S_DIV  = 3'd3,
    S_FIX  = 3'd4
  } state_t;

  state_t                state_r, state_nxt_s;
  logic                  accept_s, out_free_s;
  logic                  is_mul_s, is_div_s, div_signed_s, div_rem_s;
  logic                  div_zero_s, div_ovf_s, div_long_s;
  logic [SH_W-1:0]       shamt_s;
  logic [XLEN-1:0]       single_res_s, mul_res_s, fix_res_s, fix_q_s, fix_r_s;
  logic [XLEN-1:0]       mag_a_s, mag_b_s;
  logic                  a_sx_s, b_sx_s;
  logic [2*XLEN-1:0]     a_ext_s, b_ext_s, prod_s, product_r;
  logic [XLEN:0]         rem_sh_s, diff_s;
  logic                  ge_s;
  logic                  load_s, load_rde_s, start_mul_s, start_div_s;
  logic [XLEN-1:0]       load_data_s;
  logic [REGIDX_W-1:0]   load_idx_s;
  logic                  pend_rde_r;
  logic [REGIDX_W-1:0]   pend_idx_r;
  logic [OP_W-1:0]       pend_op_r;
  logic [XLEN-1:0]       quo_r, rem_r, dvs_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  neg_q_r, neg_rem_r, rem_sel_r;

  assign out_free_s = !valid_out || ready_in;
  assign ready_out  = (state_r == S_IDLE) && out_free_s && !flush_in;
  assign accept_s   = valid_in && ready_out;
  assign busy_out   = (state_r != S_IDLE);
  assign shamt_s    = rs2Data_in[SH_W-1:0];

  // Classify the presented opcode into multiply / divide groups.
  always_comb begin
    is_mul_s     = 1'b0;
    is_div_s     = 1'b0;
    div_signed_s = 1'b0;
    div_rem_s    = 1'b0;
    case (op_in)
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: is_mul_s = 1'b1;
      OP_DIV:  begin is_div_s = 1'b1; div_signed_s = 1'b1; end
      OP_DIVU: begin is_div_s = 1'b1; end
      OP_REM:  begin is_div_s = 1'b1; div_signed_s = 1'b1; div_rem_s = 1'b1; end
      OP_REMU: begin is_div_s = 1'b1; div_rem_s = 1'b1; end
      default: is_mul_s = 1'b0;
    endcase
  end

  assign div_zero_s = (rs2Data_in == {XLEN{1'b0}});
  assign div_ovf_s  = div_signed_s && (rs1Data_in == XMIN) && (rs2Data_in == {XLEN{1'b1}});
  assign div_long_s = is_div_s && !div_zero_s && !div_ovf_s;

  // Single-cycle results, including the divide corner cases that skip iteration.
  always_comb begin
    single_res_s = {XLEN{1'b0}};
    case (op_in)
      OP_ADD:  single_res_s = rs1Data_in + rs2Data_in;
      OP_SUB:  single_res_s = rs1Data_in - rs2Data_in;
      OP_SLL:  single_res_s = rs1Data_in << shamt_s;
      OP_SLT:  single_res_s = {{(XLEN-1){1'b0}}, ($signed(rs1Data_in) < $signed(rs2Data_in))};
      OP_SLTU: single_res_s = {{(XLEN-1){1'b0}}, (rs1Data_in < rs2Data_in)};
      OP_XOR:  single_res_s = rs1Data_in ^ rs2Data_in;
      OP_SRL:  single_res_s = rs1Data_in >> shamt_s;
      OP_SRA:  single_res_s = $unsigned($signed(rs1Data_in) >>> shamt_s);
      OP_OR:   single_res_s = rs1Data_in | rs2Data_in;
      OP_AND:  single_res_s = rs1Data_in & rs2Data_in;
      OP_DIV, OP_DIVU: single_res_s = div_zero_s ? {XLEN{1'b1}} : rs1Data_in;
      OP_REM, OP_REMU: single_res_s = div_zero_s ? rs1Data_in : {XLEN{1'b0}};
      default: single_res_s = {XLEN{1'b0}};
    endcase
  end

  // One 2*XLEN multiplier covers all four variants via per-operand sign extension.
  assign a_sx_s  = ((op_in == OP_MULH) || (op_in == OP_MULHSU)) && rs1Data_in[XLEN-1];
  assign b_sx_s  = (op_in == OP_MULH) && rs2Data_in[XLEN-1];
  assign a_ext_s = {{XLEN{a_sx_s}}, rs1Data_in};
  assign b_ext_s = {{XLEN{b_sx_s}}, rs2Data_in};
  assign prod_s  = a_ext_s * b_ext_s;
  assign mul_res_s = (pend_op_r == OP_MUL) ? product_r[XLEN-1:0] : product_r[2*XLEN-1:XLEN];

  assign mag_a_s  = (div_signed_s && rs1Data_in[XLEN-1]) ? -rs1Data_in : rs1Data_in;
  assign mag_b_s  = (div_signed_s && rs2Data_in[XLEN-1]) ? -rs2Data_in : rs2Data_in;
  assign rem_sh_s = {rem_r, quo_r[XLEN-1]};
  assign diff_s   = rem_sh_s - {1'b0, dvs_r};
  assign ge_s     = !diff_s[XLEN];
  assign fix_q_s  = neg_q_r ? -quo_r : quo_r;
  assign fix_r_s  = neg_rem_r ? -rem_r : rem_r;
  assign fix_res_s = rem_sel_r ? fix_r_s : fix_q_s;

  // Next-state and output-load decisions; flush overrides any completion.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    load_data_s = {XLEN{1'b0}};
    load_rde_s  = pend_rde_r;
    load_idx_s  = pend_idx_r;
    start_mul_s = 1'b0;
    start_div_s = 1'b0;
    if (flush_in) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s && is_mul_s) begin
            start_mul_s = 1'b1;
            state_nxt_s = S_MUL;
          end else if (accept_s && div_long_s) begin
            start_div_s = 1'b1;
            state_nxt_s = S_DIV;
          end else if (accept_s) begin
            load_s      = 1'b1;
            load_data_s = single_res_s;
            load_rde_s  = rdE_in;
            load_idx_s  = rdIdx_in;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_MUL, S_OUT: begin
          if (out_free_s) begin
            load_s      = 1'b1;
            load_data_s = mul_res_s;
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_OUT;
          end
        end
        S_DIV: begin
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = S_FIX;
          end else begin
            state_nxt_s = S_DIV;
          end
        end
        S_FIX: begin
          if (out_free_s) begin
            load_s      = 1'b1;
            load_data_s = fix_res_s;
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_FIX;
          end
        end
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operation context, product register and divider iteration registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pend_rde_r <= 1'b0;
      pend_idx_r <= {REGIDX_W{1'b0}};
      pend_op_r  <= {OP_W{1'b0}};
      product_r  <= {(2*XLEN){1'b0}};
      quo_r      <= {XLEN{1'b0}};
      rem_r      <= {XLEN{1'b0}};
      dvs_r      <= {XLEN{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      neg_q_r    <= 1'b0;
      neg_rem_r  <= 1'b0;
      rem_sel_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        pend_rde_r <= rdE_in;
        pend_idx_r <= rdIdx_in;
        pend_op_r  <= op_in;
      end
      if (start_mul_s) begin
        product_r <= prod_s;
      end
      if (start_div_s) begin
        quo_r     <= mag_a_s;
        rem_r     <= {XLEN{1'b0}};
        dvs_r     <= mag_b_s;
        cnt_r     <= {CNT_W{1'b0}};
        neg_q_r   <= div_signed_s && (rs1Data_in[XLEN-1] ^ rs2Data_in[XLEN-1]);
        neg_rem_r <= div_signed_s && rs1Data_in[XLEN-1];
        rem_sel_r <= div_rem_s;
      end else if (state_r == S_DIV) begin
        quo_r <= {quo_r[XLEN-2:0], ge_s};
        rem_r <= ge_s ? diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Output register: load on completion, hold while stalled, drop on handoff.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_out  <= 1'b0;
      rdE_out    <= 1'b0;
      rdIdx_out  <= {REGIDX_W{1'b0}};
      rdData_out <= {XLEN{1'b0}};
    end else if (flush_in) begin
      valid_out <= 1'b0;
    end else if (load_s) begin
      valid_out  <= 1'b1;
      rdE_out    <= load_rde_s;
      rdIdx_out  <= load_idx_s;
      rdData_out <= load_data_s;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_out;
    end
  end

endmodule

// File: tb/tb_ex_unit_mdu.sv
// Self-checking bench for ex_unit_mdu: directed scenarios plus randomized ops
// compared against an arithmetic reference model with a latency model.
module tb_ex_unit_mdu;

  logic        clk = 1'b0;
  logic        rst_in, valid_in, ready_out, rdE_in, flush_in;
  logic        valid_out, ready_in, rdE_out, busy_out;
  logic [4:0]  op_in, rdIdx_in, rdIdx_out;
  logic [31:0] rs1Data_in, rs2Data_in, rdData_out;
  int          n_checks = 0;
  int          n_fail   = 0;

  ex_unit_mdu #(.XLEN(32), .REGIDX_W(5), .OP_W(5)) dut (
    .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
    .op_in(op_in), .rdE_in(rdE_in), .rdIdx_in(rdIdx_in),
    .rs1Data_in(rs1Data_in), .rs2Data_in(rs2Data_in), .flush_in(flush_in),
    .valid_out(valid_out), .ready_in(ready_in), .rdE_out(rdE_out),
    .rdIdx_out(rdIdx_out), .rdData_out(rdData_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input int op, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb;
    int         ia, ib;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a << b[4:0];
      3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a >> b[4:0];
      7:  return $unsigned($signed(a) >>> b[4:0]);
      8:  return a | b;
      9:  return a & b;
      10: begin p = 64'(sa * sb); return p[31:0]; end
      11: begin p = 64'(sa * sb); return p[63:32]; end
      12: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
      13: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      14: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        else return 32'(ia / ib);
      end
      15: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      16: begin
        if (b == 32'd0) return a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        else return 32'(ia % ib);
      end
      17: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Edges from accept (inclusive) until valid_out is visible.
  function automatic int exp_lat(input int op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 10 && op <= 13) return 2;
    if (op >= 14 && op <= 17) begin
      if (b == 32'd0) return 1;
      if ((op == 14 || op == 16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
    end
    return 1;
  endfunction

  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic rde, input logic [4:0] idx, input bit hold);
    logic [31:0] exp;
    int lat, elat;
    exp  = ref_res(op, a, b);
    elat = exp_lat(op, a, b);
    @(negedge clk);
    ready_in = !hold;
    check_eq("ready_idle", 64'(ready_out), 64'd1);
    valid_in = 1'b1; op_in = 5'(op); rs1Data_in = a; rs2Data_in = b;
    rdE_in = rde; rdIdx_in = idx;
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat = 1;
    while (!valid_out && lat < 60) begin
      if (elat > 2 && lat == 5) begin
        check_eq("busy_div", 64'(busy_out), 64'd1);
        check_eq("ready_div", 64'(ready_out), 64'd0);
      end
      @(posedge clk); #1;
      lat++;
    end
    check_eq($sformatf("lat_op%0d", op), 64'(lat), 64'(elat));
    check_eq($sformatf("data_op%0d", op), 64'(rdData_out), 64'(exp));
    check_eq("rd_idx", 64'(rdIdx_out), 64'(idx));
    check_eq("rd_en", 64'(rdE_out), 64'(rde));
    if (hold) begin
      for (int k = 0; k < 2; k++) begin
        @(posedge clk); #1;
        check_eq("hold_valid", 64'(valid_out), 64'd1);
        check_eq("hold_data", 64'(rdData_out), 64'(exp));
      end
      ready_in = 1'b1;
    end
    @(posedge clk); #1;
    check_eq("drain", 64'(valid_out), 64'd0);
  endtask

  initial begin
    bit seen;
    rst_in = 1'b1; valid_in = 1'b0; flush_in = 1'b0; ready_in = 1'b1;
    op_in = 5'd0; rdE_in = 1'b0; rdIdx_in = 5'd0; rs1Data_in = 32'd0; rs2Data_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(valid_out), 64'd0);
    check_eq("rst_rde", 64'(rdE_out), 64'd0);
    check_eq("rst_idx", 64'(rdIdx_out), 64'd0);
    check_eq("rst_data", 64'(rdData_out), 64'd0);
    check_eq("rst_busy", 64'(busy_out), 64'd0);
    @(negedge clk); rst_in = 1'b0;

    run_op(0, 32'h7FFF_FFFF, 32'd1, 1'b1, 5'd7, 1'b0);

    // Back-to-back SRA then SLTU at full throughput.
    @(negedge clk);
    ready_in = 1'b1; valid_in = 1'b1; op_in = 5'd7; rs1Data_in = 32'h8000_0000;
    rs2Data_in = 32'd4; rdE_in = 1'b1; rdIdx_in = 5'd3;
    check_eq("b2b_ready0", 64'(ready_out), 64'd1);
    @(posedge clk); #1;
    op_in = 5'd4; rs1Data_in = 32'd1; rs2Data_in = 32'hFFFF_FFFF; rdIdx_in = 5'd4;
    check_eq("b2b_valid0", 64'(valid_out), 64'd1);
    check_eq("b2b_sra", 64'(rdData_out), 64'h0000_0000_F800_0000);
    check_eq("b2b_idx0", 64'(rdIdx_out), 64'd3);
    check_eq("b2b_ready1", 64'(ready_out), 64'd1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    check_eq("b2b_valid1", 64'(valid_out), 64'd1);
    check_eq("b2b_sltu", 64'(rdData_out), 64'd1);
    check_eq("b2b_idx1", 64'(rdIdx_out), 64'd4);
    @(posedge clk); #1;
    check_eq("b2b_drain", 64'(valid_out), 64'd0);

    run_op(11, 32'hFFFF_FFFF, 32'd2, 1'b1, 5'd8, 1'b0);
    run_op(13, 32'hFFFF_FFFF, 32'd2, 1'b1, 5'd9, 1'b0);
    run_op(14, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd10, 1'b0);
    run_op(16, 32'hFFFF_FFF9, 32'd2, 1'b0, 5'd11, 1'b0);
    run_op(15, 32'd5, 32'd0, 1'b1, 5'd12, 1'b0);
    run_op(14, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd13, 1'b0);
    run_op(16, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd14, 1'b0);
    run_op(12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd15, 1'b1);

    // Held ADD result, DIV presented behind it, then flushed mid-iteration.
    @(negedge clk);
    ready_in = 1'b0; valid_in = 1'b1; op_in = 5'd0; rs1Data_in = 32'd10;
    rs2Data_in = 32'd20; rdE_in = 1'b1; rdIdx_in = 5'd9;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check_eq("fl_add_valid", 64'(valid_out), 64'd1);
    check_eq("fl_add_data", 64'(rdData_out), 64'd30);
    @(negedge clk);
    valid_in = 1'b1; op_in = 5'd14; rs1Data_in = 32'd1000; rs2Data_in = 32'd7; rdIdx_in = 5'd10;
    check_eq("fl_ready_held", 64'(ready_out), 64'd0);
    @(posedge clk); #1;
    check_eq("fl_hold_data", 64'(rdData_out), 64'd30);
    check_eq("fl_hold_valid", 64'(valid_out), 64'd1);
    @(negedge clk); ready_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check_eq("fl_handoff", 64'(valid_out), 64'd0);
    check_eq("fl_busy", 64'(busy_out), 64'd1);
    repeat (9) @(posedge clk);
    @(negedge clk); flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    check_eq("fl_valid", 64'(valid_out), 64'd0);
    check_eq("fl_idle", 64'(busy_out), 64'd0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (valid_out) seen = 1'b1; end
    check_eq("fl_no_result", 64'(seen), 64'd0);

    // Reset during a divide aborts it.
    @(negedge clk);
    valid_in = 1'b1; op_in = 5'd15; rs1Data_in = 32'd12345; rs2Data_in = 32'd11; rdIdx_in = 5'd21;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    check_eq("rs_valid", 64'(valid_out), 64'd0);
    check_eq("rs_busy", 64'(busy_out), 64'd0);
    check_eq("rs_data", 64'(rdData_out), 64'd0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (valid_out) seen = 1'b1; end
    check_eq("rs_no_result", 64'(seen), 64'd0);

    for (int i = 0; i < 60; i++) begin
      int          op;
      logic [31:0] a, b;
      op = int'($urandom_range(0, 20));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 100)); b = 32'($urandom_range(1, 9)); end
        3: begin a = -32'($urandom_range(0, 100)); b = 32'($urandom_range(1, 9)); end
        default: a = a;
      endcase
      run_op(op, a, b, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
